// File: rtl/zx_spi_master_pkg.sv
// Shared constants for the ZX SPI master: divider codes, control-register layout,
// default port addresses and the half-period reload helper.
package zx_spi_master_pkg;

    localparam logic [2:0] SPI_DIV_7M   = 3'd0;
    localparam logic [2:0] SPI_DIV_INIT = 3'd5;
    localparam logic [2:0] SPI_DIV_SLOW = 3'd7;

    localparam int CTRL_BUSY   = 7;
    localparam int CTRL_DIV_HI = 6;
    localparam int CTRL_DIV_LO = 4;

    localparam logic [7:0] PORT_DATA_DEF = 8'hEB;
    localparam logic [7:0] PORT_CTRL_DEF = 8'hE7;

    typedef enum logic {
        SH_IDLE,
        SH_XFER
    } sh_state_e;

    // Down-counter reload for one SCK half period: 2^(div+1) cycles, counted to zero.
    function automatic logic [7:0] half_reload(input logic [2:0] div);
        logic [8:0] h;
        h = (9'd2 << div) - 9'd1;
        return h[7:0];
    endfunction

endpackage

// File: rtl/cpu_bus.sv
// ZX I/O bus signals as seen by port-mapped peripherals.
interface cpu_bus;
    logic [7:0] a;
    logic [7:0] d;
    logic       rd;
    logic       wr;
    logic       ioreq;

    modport slave (input a, input d, input rd, input wr, input ioreq);
endinterface

// File: rtl/zx_spi_shifter.sv
// SPI mode-0 byte engine: half-period down-counter, bit sequencing, MOSI/MISO shifting.
// A start on the completion cycle chains the next byte with no idle gap.
module zx_spi_shifter
    import zx_spi_master_pkg::*;
(
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx,
    input  logic [2:0] div,
    input  logic       miso,
    output logic       done,
    output logic [7:0] rx,
    output logic       active,
    output logic       sck,
    output logic       mosi
);

    sh_state_e  state_q;
    logic [7:0] cnt_q;
    logic [3:0] half_q;
    logic [2:0] div_q;
    logic [7:0] tx_q;
    logic [7:0] sh_q;
    logic [7:0] rx_q;
    logic       sck_q;
    logic       mosi_q;

    assign active = (state_q == SH_XFER);
    assign done   = active && (cnt_q == 8'd0) && (half_q == 4'd15);
    assign rx     = rx_q;
    assign sck    = sck_q;
    assign mosi   = mosi_q;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SH_IDLE;
            cnt_q   <= 8'd0;
            half_q  <= 4'd0;
            div_q   <= 3'd0;
            tx_q    <= 8'd0;
            sh_q    <= 8'd0;
            rx_q    <= 8'hFF;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
        end else begin
            if (done)
                rx_q <= sh_q;
            if (start) begin
                state_q <= SH_XFER;
                div_q   <= div;
                cnt_q   <= half_reload(div);
                half_q  <= 4'd0;
                tx_q    <= tx;
                mosi_q  <= tx[7];
                sck_q   <= 1'b0;
            end else if (state_q == SH_XFER) begin
                if (cnt_q != 8'd0) begin
                    cnt_q <= cnt_q - 8'd1;
                end else begin
                    cnt_q  <= half_reload(div_q);
                    half_q <= half_q + 4'd1;
                    if (!half_q[0]) begin
                        sck_q <= 1'b1;
                        sh_q  <= {sh_q[6:0], miso};
                    end else begin
                        sck_q <= 1'b0;
                        if (half_q == 4'd15) begin
                            state_q <= SH_IDLE;
                            mosi_q  <= 1'b1;
                        end else begin
                            tx_q   <= {tx_q[6:0], 1'b0};
                            mosi_q <= tx_q[6];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/zx_spi_master.sv
// Port-mapped SPI master for the ZX I/O bus: access decode, control register,
// 1-deep TX holding buffer with read-ahead, and CPU read mux.
module zx_spi_master
    import zx_spi_master_pkg::*;
#(
    parameter int         N_CS      = 1,
    parameter logic [7:0] PORT_DATA = PORT_DATA_DEF,
    parameter logic [7:0] PORT_CTRL = PORT_CTRL_DEF,
    parameter logic [2:0] DIV_RESET = SPI_DIV_7M
) (
    input  logic            clk28,
    input  logic            rst_n,
    input  logic            en,
    cpu_bus.slave           bus,
    output logic [7:0]      d_out,
    output logic            d_out_active,
    input  logic            spi_miso,
    output logic            spi_mosi,
    output logic            spi_sck,
    output logic [N_CS-1:0] spi_cs_n,
    output logic            busy
);

    logic            data_acc_q, ctrl_acc_q;
    logic [N_CS-1:0] cs_n_q;
    logic [2:0]      div_q;
    logic            pend_q, pend_d;
    logic [7:0]      hold_q, hold_d;
    logic [7:0]      d_out_q;
    logic            act_q;

    logic       sh_start, sh_done, sh_active;
    logic [7:0] sh_tx, sh_rx;

    logic data_cs, ctrl_cs, data_acc, ctrl_acc, data_det, ctrl_det, is_rd;
    logic start_hold, start_new;
    logic [7:0] tx_byte, ctrl_val;
    logic [3:0] cs_pad;

    assign data_cs  = en & bus.ioreq & (bus.a == PORT_DATA);
    assign ctrl_cs  = en & bus.ioreq & (bus.a == PORT_CTRL);
    assign data_acc = data_cs & (bus.rd | bus.wr);
    assign ctrl_acc = ctrl_cs & (bus.rd | bus.wr);
    assign data_det = data_acc & ~data_acc_q;
    assign ctrl_det = ctrl_acc & ~ctrl_acc_q;
    assign is_rd    = bus.rd & ~bus.wr;
    assign tx_byte  = bus.wr ? bus.d : 8'hFF;

    assign busy = sh_active | pend_q;

    // An access landing on the completion cycle still counts as busy and goes to the holding buffer.
    assign start_hold = pend_q & (~sh_active | sh_done);
    assign start_new  = data_det & ~sh_active & ~pend_q;
    assign sh_start   = start_hold | start_new;
    assign sh_tx      = start_hold ? hold_q : tx_byte;

    always_comb begin
        pend_d = pend_q;
        hold_d = hold_q;
        if (start_hold)
            pend_d = 1'b0;
        if (data_det & ~start_new) begin
            pend_d = 1'b1;
            hold_d = tx_byte;
        end
    end

    always_comb begin
        cs_pad           = 4'hF;
        cs_pad[N_CS-1:0] = cs_n_q;
    end

    assign ctrl_val = {busy, div_q, cs_pad};

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            data_acc_q <= 1'b0;
            ctrl_acc_q <= 1'b0;
            cs_n_q     <= {N_CS{1'b1}};
            div_q      <= DIV_RESET;
            pend_q     <= 1'b0;
            hold_q     <= 8'hFF;
            d_out_q    <= 8'h00;
            act_q      <= 1'b0;
        end else begin
            data_acc_q <= data_acc;
            ctrl_acc_q <= ctrl_acc;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            if (ctrl_det & bus.wr) begin
                cs_n_q <= bus.d[N_CS-1:0];
                div_q  <= bus.d[CTRL_DIV_HI:CTRL_DIV_LO];
            end
            if (ctrl_det & is_rd)
                d_out_q <= ctrl_val;
            if (data_det & is_rd)
                d_out_q <= sh_rx;
            act_q <= ((data_det | ctrl_det) & is_rd) | (act_q & (data_cs | ctrl_cs) & bus.rd);
        end
    end

    assign d_out        = d_out_q;
    assign d_out_active = act_q & en;
    assign spi_cs_n     = cs_n_q;

    zx_spi_shifter u_shifter (
        .clk28  (clk28),
        .rst_n  (rst_n),
        .start  (sh_start),
        .tx     (sh_tx),
        .div    (div_q),
        .miso   (spi_miso),
        .done   (sh_done),
        .rx     (sh_rx),
        .active (sh_active),
        .sck    (spi_sck),
        .mosi   (spi_mosi)
    );

endmodule

// File: tb/tb_zx_spi_master.sv
// Directed bench for zx_spi_master: port accesses, wire-level SPI capture with a MISO
// pattern source, divider timing, holding-buffer behaviour and mid-transfer reset.
module tb_zx_spi_master;

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b1;
    logic [7:0] d_out;
    logic       d_out_active;
    logic       spi_miso = 1'b1;
    logic       spi_mosi;
    logic       spi_sck;
    logic [0:0] spi_cs_n;
    logic       busy;

    cpu_bus bus_if ();

    zx_spi_master #(.N_CS(1)) dut (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .en           (en),
        .bus          (bus_if),
        .d_out        (d_out),
        .d_out_active (d_out_active),
        .spi_miso     (spi_miso),
        .spi_mosi     (spi_mosi),
        .spi_sck      (spi_sck),
        .spi_cs_n     (spi_cs_n),
        .busy         (busy)
    );

    always #5 clk28 = ~clk28;

    int cyc = 0;
    always @(posedge clk28) cyc++;

    // Wire monitor: MOSI captured at each SCK rise, MISO served MSB first per byte.
    logic [15:0] mosi_sr = 16'h0000;
    logic [7:0]  miso_byte = 8'hFF;
    logic [2:0]  bit_idx = 3'd0;
    logic        sck_prev = 1'b0;
    logic        busy_prev = 1'b0;
    int rise_total = 0;
    int busy_total = 0;
    int busy_falls = 0;
    int last_rise_cyc = 0;
    int period = 0;

    always @(negedge clk28) begin
        if (spi_sck && !sck_prev) begin
            mosi_sr = {mosi_sr[14:0], spi_mosi};
            rise_total++;
            period = cyc - last_rise_cyc;
            last_rise_cyc = cyc;
            bit_idx = bit_idx + 3'd1;
        end
        if (busy) busy_total++;
        if (!busy && busy_prev) busy_falls++;
        busy_prev = busy;
        sck_prev = spi_sck;
        if (!busy || !rst_n) bit_idx = 3'd0;
        spi_miso = miso_byte[3'd7 - bit_idx];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic io_wr(input logic [7:0] port, input logic [7:0] data);
        @(negedge clk28);
        bus_if.a = port; bus_if.d = data; bus_if.ioreq = 1'b1; bus_if.wr = 1'b1;
        repeat (2) @(negedge clk28);
        bus_if.ioreq = 1'b0; bus_if.wr = 1'b0;
    endtask

    task automatic io_rd(input logic [7:0] port, output logic [7:0] data, output logic act);
        @(negedge clk28);
        bus_if.a = port; bus_if.ioreq = 1'b1; bus_if.rd = 1'b1;
        @(negedge clk28);
        data = d_out;
        act  = d_out_active;
        @(negedge clk28);
        bus_if.ioreq = 1'b0; bus_if.rd = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk28);
            n++;
        end
        #1;
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] rd_val;
        logic       rd_act;
        int snap_busy, snap_rise, snap_falls, n;

        bus_if.a = 8'h00; bus_if.d = 8'h00;
        bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.ioreq = 1'b0;
        repeat (3) @(negedge clk28);
        rst_n = 1'b1;
        @(negedge clk28);

        check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("rst_sck",  {31'd0, spi_sck},  32'd0);
        check("rst_mosi", {31'd0, spi_mosi}, 32'd1);
        check("rst_busy", {31'd0, busy},     32'd0);
        check("rst_act",  {31'd0, d_out_active}, 32'd0);
        io_rd(8'hE7, rd_val, rd_act);
        check("rst_ctrl", {24'd0, rd_val}, 32'h0F);

        // Single byte at div0
        io_wr(8'hE7, 8'h00);
        check("cs_low", {31'd0, spi_cs_n}, 32'd0);
        miso_byte = 8'h3C;
        snap_busy = busy_total; snap_rise = rise_total;
        io_wr(8'hEB, 8'hA5);
        io_rd(8'hE7, rd_val, rd_act);
        check("ctrl_busy", {24'd0, rd_val}, 32'h8E);
        wait_idle("idle_a5", 200);
        check("mosi_a5",   {24'd0, mosi_sr[7:0]}, 32'hA5);
        check("rises_a5",  rise_total - snap_rise, 8);
        check("period_a5", period, 4);
        check("busy_a5",   busy_total - snap_busy, 32);

        // Read-ahead: returns previous byte and clocks out FF
        miso_byte = 8'h96;
        snap_busy = busy_total;
        io_rd(8'hEB, rd_val, rd_act);
        check("rd_3c",  {24'd0, rd_val}, 32'h3C);
        check("rd_act", {31'd0, rd_act}, 32'd1);
        @(negedge clk28);
        check("rd_act_drop", {31'd0, d_out_active}, 32'd0);
        wait_idle("idle_ff", 200);
        check("mosi_ff", {24'd0, mosi_sr[7:0]}, 32'hFF);
        check("busy_ff", busy_total - snap_busy, 32);
        io_rd(8'hEB, rd_val, rd_act);
        check("rd_96", {24'd0, rd_val}, 32'h96);
        wait_idle("idle_ra", 200);

        // Back-to-back writes: 0x22 overwritten by 0x33 in the holding buffer
        miso_byte = 8'h5A;
        snap_busy = busy_total; snap_rise = rise_total; snap_falls = busy_falls;
        io_wr(8'hEB, 8'h11);
        io_wr(8'hEB, 8'h22);
        io_wr(8'hEB, 8'h33);
        wait_idle("idle_b2b", 400);
        check("mosi_b2b",  {16'd0, mosi_sr}, 32'h1133);
        check("busy_b2b",  busy_total - snap_busy, 64);
        check("falls_b2b", busy_falls - snap_falls, 1);
        check("rises_b2b", rise_total - snap_rise, 16);
        io_rd(8'hEB, rd_val, rd_act);
        check("rd_5a", {24'd0, rd_val}, 32'h5A);
        wait_idle("idle_rd5a", 200);

        // Divider 5
        io_wr(8'hE7, 8'h50);
        io_rd(8'hE7, rd_val, rd_act);
        check("ctrl_div5", {24'd0, rd_val}, 32'h5E);
        snap_busy = busy_total; snap_rise = rise_total;
        io_wr(8'hEB, 8'h00);
        wait_idle("idle_div5", 3000);
        check("period_div5", period, 128);
        check("busy_div5",   busy_total - snap_busy, 1024);
        check("rises_div5",  rise_total - snap_rise, 8);

        // Divider change mid-transfer applies only to the queued byte
        snap_busy = busy_total;
        io_wr(8'hEB, 8'h00);
        io_wr(8'hE7, 8'h00);
        io_wr(8'hEB, 8'hC3);
        wait_idle("idle_divchg", 3000);
        check("busy_divchg",   busy_total - snap_busy, 1056);
        check("mosi_divchg",   {16'd0, mosi_sr}, 32'h00C3);
        check("period_divchg", period, 4);

        // Reset during bit 3
        snap_rise = rise_total;
        io_wr(8'hEB, 8'hA5);
        n = 0;
        while ((rise_total - snap_rise) < 3 && n < 200) begin
            @(negedge clk28);
            #1;
            n++;
        end
        check("mid_rises", rise_total - snap_rise, 3);
        rst_n = 1'b0;
        #1;
        check("mid_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("mid_sck",  {31'd0, spi_sck},  32'd0);
        check("mid_mosi", {31'd0, spi_mosi}, 32'd1);
        check("mid_busy", {31'd0, busy},     32'd0);
        check("mid_act",  {31'd0, d_out_active}, 32'd0);
        repeat (2) @(negedge clk28);
        rst_n = 1'b1;
        io_rd(8'hE7, rd_val, rd_act);
        check("post_ctrl", {24'd0, rd_val}, 32'h0F);
        io_rd(8'hEB, rd_val, rd_act);
        check("post_rx", {24'd0, rd_val}, 32'hFF);
        wait_idle("idle_post", 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
